mem_port_arbiter: RTL and testbench

Shares the core's single memory port between the instruction-fetch requester and the load/store (data) requester of the multicycle core. It accepts one request at a time, drives it to memory with a valid/ready handshake, and waits for the response. It then routes read data or write completion back to the requester that owns the transaction. Contention is resolved round-robin, so neither side starves.

---
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the shared memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              if_valid_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ready_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              d_valid_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [MASK_W-1:0] d_wmask_i;
  logic              d_ready_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;

  logic              mem_valid_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [MASK_W-1:0] mem_wmask_o;
  logic              mem_ready_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              busy_o;

  // Arbiter side
  modport slave (
    input  if_valid_i, if_addr_i,
    output if_ready_o, if_rvalid_o, if_rdata_o,
    input  d_valid_i, d_we_i, d_addr_i, d_wdata_i, d_wmask_i,
    output d_ready_o, d_rvalid_o, d_rdata_o,
    output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
    output busy_o
  );

  // Requester/memory side (environment)
  modport master (
    output if_valid_i, if_addr_i,
    input  if_ready_o, if_rvalid_o, if_rdata_o,
    output d_valid_i, d_we_i, d_addr_i, d_wdata_i, d_wmask_i,
    input  d_ready_o, d_rvalid_o, d_rdata_o,
    input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  mem_port_arbiter_if.slave  bus
);
  localparam int unsigned MASK_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  logic grant_f_c, grant_d_c, done_c, mem_valid_c;

  // Next state, grant decision and completion detect; reset masks everything
  always_comb begin
    state_d     = state_q;
    grant_f_c   = 1'b0;
    grant_d_c   = 1'b0;
    done_c      = 1'b0;
    mem_valid_c = 1'b0;
    if (!reset_i) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.d_valid_i && (!bus.if_valid_i || last_grant_q == OWN_FETCH)) begin
            grant_d_c = 1'b1;
          end else if (bus.if_valid_i) begin
            grant_f_c = 1'b1;
          end
          if (grant_d_c || grant_f_c) state_d = ST_REQ;
        end
        ST_REQ: begin
          mem_valid_c = 1'b1;
          if (bus.mem_ready_i) begin
            if (bus.mem_rvalid_i) begin
              done_c  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (bus.mem_rvalid_i) begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Latch the granted request; fetches and loads carry no write data or mask
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant_q <= OWN_FETCH;
      owner_q      <= OWN_FETCH;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else if (grant_d_c || grant_f_c) begin
      last_grant_q <= grant_d_c;
      owner_q      <= grant_d_c;
      we_q         <= grant_d_c && bus.d_we_i;
      addr_q       <= grant_d_c ? bus.d_addr_i : bus.if_addr_i;
      wdata_q      <= (grant_d_c && bus.d_we_i) ? bus.d_wdata_i : '0;
      wmask_q      <= (grant_d_c && bus.d_we_i) ? bus.d_wmask_i : '0;
    end
  end

  // Memory side is driven only while a request is offered
  assign bus.mem_valid_o = mem_valid_c;
  assign bus.mem_we_o    = mem_valid_c && we_q;
  assign bus.mem_addr_o  = mem_valid_c ? addr_q  : '0;
  assign bus.mem_wdata_o = mem_valid_c ? wdata_q : '0;
  assign bus.mem_wmask_o = mem_valid_c ? wmask_q : '0;

  // Requester handshakes and response routing to the transaction owner
  assign bus.if_ready_o  = grant_f_c;
  assign bus.d_ready_o   = grant_d_c;
  assign bus.if_rvalid_o = done_c && (owner_q == OWN_FETCH);
  assign bus.d_rvalid_o  = done_c && (owner_q == OWN_DATA);
  assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.d_rdata_o   = bus.d_rvalid_o  ? bus.mem_rdata_i : '0;
  assign bus.busy_o      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;

  logic clk_i = 1'b0;
  logic reset_i;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) io ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (io)
  );

  always #5 clk_i = ~clk_i;

  // Model: at most one pending transaction record plus the round-robin memory
  bit              m_busy;
  bit              m_acc;
  bit              m_own_data;
  bit              m_we;
  bit [ADDR_W-1:0] m_addr;
  bit [DATA_W-1:0] m_wdata;
  bit [MASK_W-1:0] m_wmask;
  bit              m_last_data;
  bit              e_gd, e_gf, e_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compute this cycle's expected outputs and compare everything
  task automatic settle();
    bit offer;
    #1;
    e_gd = 1'b0; e_gf = 1'b0; e_done = 1'b0;
    if (!reset_i && !m_busy) begin
      if (io.d_valid_i && io.if_valid_i) begin
        e_gd = !m_last_data;
        e_gf = m_last_data;
      end else begin
        e_gd = io.d_valid_i;
        e_gf = io.if_valid_i;
      end
    end
    offer = !reset_i && m_busy && !m_acc;
    if (!reset_i && m_busy) e_done = io.mem_rvalid_i && (m_acc || io.mem_ready_i);
    chk("if_ready",  io.if_ready_o, e_gf);
    chk("d_ready",   io.d_ready_o,  e_gd);
    chk("mem_valid", io.mem_valid_o, offer);
    chk("mem_we",    io.mem_we_o,    offer ? m_we : 1'b0);
    chk("mem_addr",  io.mem_addr_o,  offer ? m_addr : '0);
    chk("mem_wdata", io.mem_wdata_o, offer ? m_wdata : '0);
    chk("mem_wmask", io.mem_wmask_o, offer ? m_wmask : '0);
    chk("if_rvalid", io.if_rvalid_o, e_done && !m_own_data);
    chk("d_rvalid",  io.d_rvalid_o,  e_done && m_own_data);
    chk("if_rdata",  io.if_rdata_o,  (e_done && !m_own_data) ? io.mem_rdata_i : '0);
    chk("d_rdata",   io.d_rdata_o,   (e_done && m_own_data) ? io.mem_rdata_i : '0);
    chk("busy",      io.busy_o,      m_busy);
  endtask

  // Advance one clock and update the model from the inputs seen at that edge
  task automatic tick();
    @(posedge clk_i);
    if (reset_i) begin
      m_busy = 1'b0; m_acc = 1'b0; m_last_data = 1'b0;
    end else if (e_gd || e_gf) begin
      m_busy = 1'b1; m_acc = 1'b0;
      m_own_data  = e_gd;
      m_last_data = e_gd;
      m_we    = e_gd && io.d_we_i;
      m_addr  = e_gd ? io.d_addr_i : io.if_addr_i;
      m_wdata = (e_gd && io.d_we_i) ? io.d_wdata_i : '0;
      m_wmask = (e_gd && io.d_we_i) ? io.d_wmask_i : '0;
    end else if (m_busy) begin
      if (e_done) m_busy = 1'b0;
      else if (io.mem_ready_i) m_acc = 1'b1;
    end
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    io.if_valid_i = 0; io.if_addr_i = '0;
    io.d_valid_i = 0; io.d_we_i = 0; io.d_addr_i = '0; io.d_wdata_i = '0; io.d_wmask_i = '0;
    io.mem_ready_i = 0; io.mem_rvalid_i = 0; io.mem_rdata_i = '0;
  endtask

  initial begin
    bit grants [$];
    bit pattern [6];
    int guard;
    int busy_cycles;

    idle_inputs();
    reset_i = 1'b1;
    m_busy = 0; m_acc = 0; m_last_data = 0; m_own_data = 0;
    m_we = 0; m_addr = '0; m_wdata = '0; m_wmask = '0;
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    settle(); tick();

    // 1: single fetch, memory ready after 2 waits, response a cycle later
    reset_i = 0;
    io.if_valid_i = 1; io.if_addr_i = 32'h100;
    settle(); chk("t1_if_ready", io.if_ready_o, 1'b1); tick();
    io.if_valid_i = 0; io.if_addr_i = 32'hFFFF;
    for (int i = 0; i < 2; i++) begin
      settle(); chk("t1_hold_addr", io.mem_addr_o, 32'h100); chk("t1_hold_we", io.mem_we_o, 1'b0); tick();
    end
    io.mem_ready_i = 1;
    settle(); tick();
    io.mem_ready_i = 0; io.mem_rvalid_i = 1; io.mem_rdata_i = 32'hDEADBEEF;
    settle();
    chk("t1_if_rvalid", io.if_rvalid_o, 1'b1);
    chk("t1_if_rdata", io.if_rdata_o, 32'hDEADBEEF);
    chk("t1_d_rvalid", io.d_rvalid_o, 1'b0);
    tick();
    idle_inputs();

    // 2: contention right after reset goes to data first
    reset_i = 1; settle(); tick(); reset_i = 0;
    io.if_valid_i = 1; io.if_addr_i = 32'h200;
    io.d_valid_i = 1; io.d_we_i = 0; io.d_addr_i = 32'h300;
    settle(); chk("t2_d_first", io.d_ready_o, 1'b1); chk("t2_f_wait", io.if_ready_o, 1'b0); tick();
    io.d_valid_i = 0; io.mem_ready_i = 1;
    settle(); chk("t2_addr_d", io.mem_addr_o, 32'h300); tick();
    io.mem_ready_i = 0; io.mem_rvalid_i = 1; io.mem_rdata_i = 32'h0000AAAA;
    settle(); chk("t2_d_rdata", io.d_rdata_o, 32'h0000AAAA); chk("t2_no_if_rv", io.if_rvalid_o, 1'b0); tick();
    io.mem_rvalid_i = 0;
    settle(); chk("t2_f_next", io.if_ready_o, 1'b1); tick();
    io.if_valid_i = 0; io.mem_ready_i = 1; io.mem_rvalid_i = 1; io.mem_rdata_i = 32'h0000BBBB;
    settle(); chk("t2_if_rdata", io.if_rdata_o, 32'h0000BBBB); chk("t2_no_d_rv", io.d_rvalid_o, 1'b0); tick();
    idle_inputs();

    // 3: both held valid for six transactions alternate D,F,D,F,D,F
    io.if_valid_i = 1; io.if_addr_i = 32'h400;
    io.d_valid_i = 1; io.d_addr_i = 32'h500;
    io.mem_ready_i = 1; io.mem_rvalid_i = 1;
    guard = 0;
    while (grants.size() < 6 && guard < 40) begin
      settle();
      if (io.d_ready_o === 1'b1) grants.push_back(1'b1);
      else if (io.if_ready_o === 1'b1) grants.push_back(1'b0);
      tick();
      guard++;
    end
    chk("t3_grant_count", 64'(grants.size()), 64'd6);
    pattern = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6 && i < grants.size(); i++) chk("t3_grant_order", grants[i], pattern[i]);
    // Drain whatever was just granted before the next test
    io.if_valid_i = 0; io.d_valid_i = 0;
    for (int i = 0; i < 2; i++) begin settle(); tick(); end
    idle_inputs();

    // 4: store with same-cycle ready and rvalid occupies two cycles
    io.d_valid_i = 1; io.d_we_i = 1; io.d_addr_i = 32'h40;
    io.d_wdata_i = 32'h12345678; io.d_wmask_i = 4'b0011;
    busy_cycles = 0;
    settle(); chk("t4_d_ready", io.d_ready_o, 1'b1); tick();
    idle_inputs();
    io.mem_ready_i = 1; io.mem_rvalid_i = 1; io.mem_rdata_i = 32'h0BADF00D;
    settle();
    chk("t4_we", io.mem_we_o, 1'b1);
    chk("t4_wmask", io.mem_wmask_o, 4'b0011);
    chk("t4_wdata", io.mem_wdata_o, 32'h12345678);
    chk("t4_d_rvalid", io.d_rvalid_o, 1'b1);
    if (io.busy_o === 1'b1) busy_cycles++;
    tick();
    idle_inputs();
    settle(); chk("t4_busy_after", io.busy_o, 1'b0); tick();
    chk("t4_busy_cycles", 64'(busy_cycles), 64'd1);

    // 5: reset while waiting in RESP drops the transaction
    io.if_valid_i = 1; io.if_addr_i = 32'h900;
    settle(); tick();
    io.if_valid_i = 0; io.mem_ready_i = 1;
    settle(); tick();
    io.mem_ready_i = 0;
    settle(); chk("t5_in_resp", io.busy_o, 1'b1); tick();
    reset_i = 1;
    settle(); tick();
    reset_i = 0; io.mem_rvalid_i = 1; io.mem_rdata_i = 32'hCAFE0000;
    settle();
    chk("t5_no_if_rv", io.if_rvalid_o, 1'b0);
    chk("t5_no_d_rv", io.d_rvalid_o, 1'b0);
    chk("t5_idle", io.busy_o, 1'b0);
    chk("t5_mem_valid", io.mem_valid_o, 1'b0);
    tick();
    idle_inputs();

    // 6: spurious response in IDLE is ignored
    io.mem_rvalid_i = 1; io.mem_rdata_i = 32'h55555555;
    settle(); chk("t6_no_rv", io.if_rvalid_o | io.d_rvalid_o, 1'b0); tick();
    settle(); chk("t6_busy", io.busy_o, 1'b0); tick();
    idle_inputs();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset_i         = ($urandom_range(0, 99) == 0);
      io.if_valid_i   = ($urandom_range(0, 99) < 55);
      io.if_addr_i    = $urandom;
      io.d_valid_i    = ($urandom_range(0, 99) < 55);
      io.d_we_i       = $urandom_range(0, 1);
      io.d_addr_i     = $urandom;
      io.d_wdata_i    = $urandom;
      io.d_wmask_i    = MASK_W'($urandom);
      io.mem_ready_i  = ($urandom_range(0, 99) < 50);
      io.mem_rvalid_i = ($urandom_range(0, 99) < 40);
      io.mem_rdata_i  = $urandom;
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
